// File: rtl/ram_port0_pkg.sv
// Shared types and widths for the RAM port0 master.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package ram_port0_pkg;

    localparam int DW          = `DATA_WIDTH;
    localparam int AW          = `ADDR_WIDTH;
    localparam int WMASK_WIDTH = DW / 4;

    typedef struct packed {
        logic                   we;
        logic [AW-1:0]          addr;
        logic [DW-1:0]          wdata;
        logic [WMASK_WIDTH-1:0] wmask;
    } req_t;

    typedef logic [DW-1:0] rsp_t;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

endpackage

// File: rtl/ram_port0_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count.
module ram_port0_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_port0_master.sv
// In-order request master driving a single synchronous RAM port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module ram_port0_master
    import ram_port0_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/4-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    cs0,
    output logic                    we0,
    output logic [DATA_WIDTH/4-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0,
    output logic                    idle
);

    localparam int RQ_CW = $clog2(REQ_DEPTH) + 1;
    localparam int RS_CW = $clog2(RSP_DEPTH) + 1;

    state_e                  state_q;
    logic                    we0_q;
    logic [DATA_WIDTH/4-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0]   addr0_q;
    logic [DATA_WIDTH-1:0]   din0_q;
    logic                    rd2_q;
    logic                    rdy_q;

    req_t             in_req;
    req_t             fifo_head;
    req_t             head;
    rsp_t             rs_head;
    logic [RQ_CW-1:0] rq_count;
    logic [RS_CW-1:0] rs_count;
    logic             rq_empty;
    logic             rs_empty;
    logic             accept;
    logic             rd1;
    logic             credit;
    logic             issue;
    logic             rq_push;
    logic             rq_pop;
    logic             rs_pop;

    assign in_req = '{we: req_we, addr: req_addr,
                      wdata: req_wdata, wmask: req_wmask};

    assign rq_empty  = (rq_count == '0);
    assign rs_empty  = (rs_count == '0);
    assign req_ready = rdy_q && (rq_count != RQ_CW'(REQ_DEPTH));
    assign accept    = req_valid && req_ready;

    // An empty queue lets the incoming request issue on its accept edge.
    assign head   = rq_empty ? in_req : fifo_head;
    assign rd1    = (state_q == ACCESS) && !we0_q;
    assign credit = (int'(rs_count) + int'(rd1) + int'(rd2_q)) < RSP_DEPTH;
    assign issue  = (!rq_empty || accept) && (head.we || credit);

    assign rq_push = accept && !(rq_empty && issue);
    assign rq_pop  = issue && !rq_empty;
    assign rs_pop  = rsp_valid && rsp_ready;

    ram_port0_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk0),
        .rst_i   (rst0),
        .push_i  (rq_push),
        .data_i  (in_req),
        .pop_i   (rq_pop),
        .data_o  (fifo_head),
        .count_o (rq_count)
    );

    ram_port0_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk0),
        .rst_i   (rst0),
        .push_i  (rd2_q),
        .data_i  (dout0),
        .pop_i   (rs_pop),
        .data_o  (rs_head),
        .count_o (rs_count)
    );

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q  <= IDLE;
            we0_q    <= 1'b0;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            rd2_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            rd2_q <= rd1;
            if (issue) begin
                state_q  <= ACCESS;
                we0_q    <= head.we;
                addr0_q  <= head.addr;
                wmask0_q <= head.we ? head.wmask : '1;
                if (head.we) din0_q <= head.wdata;
            end else begin
                state_q  <= IDLE;
                we0_q    <= 1'b0;
                wmask0_q <= '0;
            end
        end
    end

    assign cs0       = (state_q == ACCESS);
    assign we0       = we0_q;
    assign wmask0    = wmask0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;
    assign rsp_valid = !rs_empty;
    assign rsp_rdata = rs_head;
    assign idle      = rq_empty && !rd1 && !rd2_q && rs_empty;

endmodule
